// File: rtl/pc_pkg.sv
// Shared fetch-path types and widths, used by the PC controller, the lookup table
// and the instruction memory.
package pc_pkg;

  localparam int PC_W  = 12;
  localparam int CNT_W = 16;

  localparam logic [PC_W-1:0] RESET_PC = 12'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable) and an
// asynchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {W{1'b0}};
    end else if (en && (cnt_q != MAX_VAL)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pc_ctrl.sv
// Program counter and fetch sequencer: IDLE/RUN/DONE launch, stall, branch,
// sequential increment and halt, with a saturating retired-instruction count.
module pc_ctrl
  import pc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             stall,
  input  logic             branch,
  input  logic             taken,
  input  logic [PC_W-1:0]  target,
  input  logic             halt,
  output logic [PC_W-1:0]  pc,
  output logic             valid,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  pc_state_t       state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic            valid_q;
  logic            done_q;
  logic            cnt_clr_s;
  logic            cnt_en_s;

  // Next-state, next-PC and counter controls; stall beats halt beats branch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pc_d      = start_addr;
          cnt_clr_s = 1'b1;
          state_d   = RUN;
        end else begin
          pc_d = RESET_PC;
        end
      end
      RUN: begin
        if (stall) begin
          pc_d = pc_q;
        end else if (halt) begin
          state_d  = DONE;
          cnt_en_s = 1'b1;
        end else if (branch && taken) begin
          pc_d     = target;
          cnt_en_s = 1'b1;
        end else begin
          pc_d     = pc_q + PC_W'(1);
          cnt_en_s = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          pc_d      = start_addr;
          cnt_clr_s = 1'b1;
          state_d   = RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = RESET_PC;
      end
    endcase
  end

  // FSM, PC and status flags, all registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .en    (cnt_en_s),
    .count (instr_count)
  );

  assign pc    = pc_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule
